// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes and debounces two raw inputs into
// one-cycle rising-edge strobes and clean levels for the sequence detector.
module input_conditioner #(
    parameter int DEBOUNCE = 4,
    localparam int CW = $clog2(DEBOUNCE + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic a_raw,
    input  logic b_raw,
    output logic A,
    output logic B,
    output logic a_level,
    output logic b_level
);
    localparam logic [3:0] LOW  = 4'b0001;
    localparam logic [3:0] RISE = 4'b0010;
    localparam logic [3:0] HIGH = 4'b0100;
    localparam logic [3:0] FALL = 4'b1000;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic [1:0] raw;
    assign raw = {b_raw, a_raw};

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic ff1, ff2, strobe, level;
        logic [3:0] state;
        logic [CW-1:0] cnt;
        always_ff @(posedge clk) begin
            if (reset) begin
                ff1    <= 1'b0;
                ff2    <= 1'b0;
                state  <= LOW;
                cnt    <= '0;
                strobe <= 1'b0;
                level  <= 1'b0;
            end else begin
                ff1    <= raw[c];
                ff2    <= ff1;
                strobe <= 1'b0;
                case (state)
                    LOW: if (ff2) begin
                        state <= RISE;
                        cnt   <= '0;
                    end
                    RISE: if (!ff2) begin
                        state <= LOW;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state  <= HIGH;
                        cnt    <= '0;
                        strobe <= 1'b1;
                        level  <= 1'b1;
                    end else cnt <= cnt + 1'b1;
                    HIGH: if (!ff2) begin
                        state <= FALL;
                        cnt   <= '0;
                    end
                    // a bounce back to 1 returns to HIGH silently: no second strobe
                    FALL: if (ff2) begin
                        state <= HIGH;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= LOW;
                        cnt   <= '0;
                        level <= 1'b0;
                    end else cnt <= cnt + 1'b1;
                    default: begin
                        state <= LOW;
                        cnt   <= '0;
                        level <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign A       = g_ch[0].strobe;
    assign B       = g_ch[1].strobe;
    assign a_level = g_ch[0].level;
    assign b_level = g_ch[1].level;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: randomized and directed stimulus scored against a
// run-length debounce model through an expected-output queue.
module tb_input_conditioner;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic a_raw = 1'b1;
    logic b_raw = 1'b1;
    logic A, B, a_level, b_level;

    input_conditioner #(.DEBOUNCE(D)) dut (
        .clk(clk), .reset(reset), .a_raw(a_raw), .b_raw(b_raw),
        .A(A), .B(B), .a_level(a_level), .b_level(b_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int model_a_strobes = 0;
    int dut_a_strobes = 0;
    logic [3:0] exp_q[$];

    // Model: a channel flips its level once its synchronized input (raw
    // delayed two edges) has disagreed with the level for D+1 straight edges.
    logic m1[2], m2[2], lvl[2], stb[2];
    int run[2];

    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            logic s, r;
            r = (c == 0) ? a_raw : b_raw;
            if (reset) begin
                m1[c] = 1'b0; m2[c] = 1'b0; lvl[c] = 1'b0; stb[c] = 1'b0; run[c] = 0;
            end else begin
                s = m2[c];
                m2[c] = m1[c];
                m1[c] = r;
                stb[c] = 1'b0;
                run[c] = (s != lvl[c]) ? run[c] + 1 : 0;
                if (run[c] == D + 1) begin
                    lvl[c] = s;
                    stb[c] = s;
                    run[c] = 0;
                end
            end
        end
        if (stb[0]) model_a_strobes++;
        exp_q.push_back({stb[0], stb[1], lvl[0], lvl[1]});
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [3:0] e, g;
            e = exp_q.pop_front();
            g = {A, B, a_level, b_level};
            if (A) dut_a_strobes++;
            checks++;
            if (g === e) passed++;
            else $display("FAIL outputs {A,B,a_level,b_level} at %0t: got %b expected %b", $time, g, e);
        end
    end

    task automatic drive(input logic a, input logic b, input logic r, input int n);
        a_raw = a;
        b_raw = b;
        reset = r;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        drive(1, 1, 1, 2);
        drive(0, 0, 0, 10);
        drive(1, 0, 0, 20);
        drive(0, 0, 0, 15);
        drive(1, 0, 0, 3);
        drive(0, 0, 0, 10);
        drive(1, 0, 0, 4);
        drive(0, 0, 0, 10);
        drive(1, 0, 0, 5);
        drive(0, 0, 0, 15);
        drive(1, 0, 0, 12);
        drive(0, 0, 0, 2);
        drive(1, 0, 0, 5);
        drive(0, 0, 0, 15);
        drive(1, 0, 0, 1);
        drive(1, 1, 0, 12);
        drive(0, 0, 0, 12);
        drive(1, 1, 0, 12);
        drive(0, 0, 0, 12);
        drive(1, 0, 0, 4);
        drive(1, 0, 1, 1);
        drive(1, 0, 0, 12);
        drive(0, 0, 0, 12);
        for (int i = 0; i < 600; i++) begin
            logic na, nb;
            na = ($urandom_range(0, 7) == 0) ? ~a_raw : a_raw;
            nb = ($urandom_range(0, 7) == 0) ? ~b_raw : b_raw;
            drive(na, nb, ($urandom_range(0, 99) == 0), 1);
        end
        drive(0, 0, 0, 12);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (dut_a_strobes == model_a_strobes) passed++;
        else $display("FAIL a_strobe_count: got %0d expected %0d", dut_a_strobes, model_a_strobes);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
